perc_argmax16: RTL and testbench
================================

# perc_argmax16

Streaming winner-take-all stage that sits directly downstream of the perceptron accumulator. It takes one frame of CLASS_NUM signed 16-bit class scores and reduces each score to its 16-bit magnitude. It tracks the largest magnitude through an internal instance of the 16-bit magnitude comparator, comp_cmp16, and emits the winning class index, magnitude and sign once per frame over a valid/ready handshake.

## Interface
- CLASS_NUM, 10: scores per frame; legal range 2..16.
- IDX_WIDTH, 4: index width; must satisfy 2^IDX_WIDTH >= CLASS_NUM.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  score beat valid.
- in_ready  output  1  stage can accept a beat.
- in_score  input  16  two's-complement class score.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_idx  output  IDX_WIDTH  winning class index (0 = first beat of the frame).
- out_mag  output  16  |score| of the winner, unsigned.
- out_sign  output  1  sign bit of the winner's original score.

## Operation
- A beat is accepted when in_valid & in_ready.
- Magnitude: mag = in_score[15] ? (~in_score + 1) : in_score, truncated to 16 bits unsigned. 0x8000 maps to magnitude 0x8000 with sign 1.
- The comparator compares a = mag (current beat) with b = best_mag (register). result = {eq, gt, lt}.
- Counter cnt (IDX_WIDTH bits) holds the index of the next beat.
- There are two states.
  - SCAN: in_ready = 1, out_valid = 0. On an accepted beat with cnt == 0, best_mag, best_idx and best_sign load unconditionally. On an accepted beat with cnt > 0, the registers update when gt = 1, and also on tie per the Configuration section. After every accepted beat, cnt increments. The beat with cnt == CLASS_NUM-1 clears cnt to 0 and moves to DONE.
  - DONE: in_ready = 0, out_valid = 1. out_idx, out_mag and out_sign equal best_idx, best_mag and best_sign, and are held stable until the handshake. When out_ready = 1, the block moves to SCAN. Best registers are not cleared; the next frame's cnt == 0 load overwrites them.
- in_valid with in_ready = 0 is not consumed; the upstream stage holds it.
- in_score is ignored unless the beat is accepted.

## Timing
- Reset values: state SCAN, cnt 0, best_mag 0, best_idx 0, best_sign 0, out_valid 0, out_idx 0, out_mag 0, out_sign 0.
- in_ready is combinational from state only; it reads 1 as soon as rst deasserts. Beats presented while rst = 1 are dropped.
- Throughput: one beat per cycle in SCAN, with no bubbles inside a frame.
- Latency: out_valid rises in the cycle after the final beat is accepted.
- Result handshake: in the cycle of out_valid & out_ready the result is consumed. in_ready = 1 from the following cycle, so the minimum frame period is CLASS_NUM + 1 cycles.
- The comparator path (abs, comp_cmp16, update decision) is purely combinational within the accept cycle. Registers update on the clk edge.
- Reset mid-frame or in DONE: the partial frame and any pending result are discarded immediately, and all registers return to their reset values. No output is produced for that frame.
- A gap in in_valid mid-frame stalls cnt. The frame resumes with no loss.

## Configuration
- ARGMAX_TIE_LAST_EN not defined: on eq = 1 the best registers keep their value, so the lowest index wins ties.
- ARGMAX_TIE_LAST_EN defined: on eq = 1 the best registers update, so the highest index wins ties.
- Nothing else changes.

## Structure
- The shared package perc_pkg holds:
  - D_WIDTH = 16;
  - the result bit positions CMP_EQ = 2, CMP_GT = 1, CMP_LT = 0;
  - the state enumeration {ST_SCAN, ST_DONE}.
- One sub-module, comp_cmp16, instantiated once and unmodified.
- The abs logic and the FSM stay inline.

## Test plan
All scenarios use CLASS_NUM = 4 unless stated.
- Frame {0x0003, 0xFFF0, 0x0007, 0x0002}: -16 has the largest magnitude → out_idx 1, out_mag 0x0010, out_sign 1; out_valid rises 1 cycle after the 4th beat.
- Frame {0x8000, 0x7FFF, 0x0000, 0x0001} → out_idx 0, out_mag 0x8000, out_sign 1.
- Ties {0x0005, 0xFFFB, 0x0005, 0x0001}:
  - without the macro → out_idx 0, out_sign 0;
  - with ARGMAX_TIE_LAST_EN → out_idx 2, out_sign 0.
- Backpressure: out_ready = 0 for 5 cycles after out_valid → outputs stable, in_ready = 0, and an offered next-frame beat is not consumed. After out_ready = 1, in_ready = 1 on the next cycle and the frame is accepted intact.
- Bubbles and reset: in_valid toggled 1/0 within a frame → correct result. A second frame with rst pulsed after beat 2 → no out_valid for that frame; the next full frame {1, 2, 9, 4} → out_idx 2, out_mag 0x0009.
- Back-to-back: two frames streamed with out_ready tied to 1 → results produced every 5 cycles, each matching a reference argmax.

Source files
------------

// File: rtl/perc_pkg.sv
// Shared definitions for the perceptron output stages.
// Holds the datapath width, the comparator result bit positions and the
// argmax FSM state encoding.
package perc_pkg;
  localparam int D_WIDTH = 16;

  // Bit positions inside the comparator result vector {eq, gt, lt}
  localparam int CMP_EQ = 2;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = 0;

  typedef enum logic {
    ST_SCAN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/perc_argmax16_if.sv
// Score-in / result-out handshake bundle for perc_argmax16.
//   in_valid/in_ready/in_score       : one signed class score per beat
//   out_valid/out_ready              : frame result handshake
//   out_idx/out_mag/out_sign         : winning class index, |score|, sign
// master = upstream/downstream side, slave = the argmax stage.
interface perc_argmax16_if #(
  parameter int IDX_WIDTH = 4
);
  import perc_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [D_WIDTH-1:0]   in_score;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_WIDTH-1:0] out_idx;
  logic [D_WIDTH-1:0]   out_mag;
  logic                 out_sign;

  modport master (
    output in_valid, in_score, out_ready,
    input  in_ready, out_valid, out_idx, out_mag, out_sign
  );

  modport slave (
    input  in_valid, in_score, out_ready,
    output in_ready, out_valid, out_idx, out_mag, out_sign
  );
endinterface

// File: rtl/comp_cmp16.sv
// 16-bit unsigned magnitude comparator.
//   a, b   : unsigned operands
//   result : {eq, gt, lt} of a relative to b (bit positions from perc_pkg)
module comp_cmp16
  import perc_pkg::*;
(
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  output logic [2:0]         result
);
  assign result[CMP_EQ] = (a == b);
  assign result[CMP_GT] = (a >  b);
  assign result[CMP_LT] = (a <  b);
endmodule

// File: rtl/perc_argmax16.sv
// Streaming winner-take-all over one frame of CLASS_NUM signed scores.
// Each score is reduced to its magnitude; the largest magnitude, its beat
// index and original sign are tracked and presented once per frame.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : perc_argmax16_if.slave (score input + result output)
// Build option: define ARGMAX_TIE_LAST_EN to let the latest equal magnitude
// win a tie; by default the earliest one is kept.
module perc_argmax16
  import perc_pkg::*;
#(
  parameter int CLASS_NUM = 10,
  parameter int IDX_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  perc_argmax16_if.slave    bus
);
  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt;
  logic [D_WIDTH-1:0]   best_mag;
  logic [IDX_WIDTH-1:0] best_idx;
  logic                 best_sign;

  logic                 in_rdy, out_vld;
  logic                 accept, last;
  logic [D_WIDTH-1:0]   mag;
  logic [2:0]           cmp;
  logic                 upd;
  logic                 cmp_lt_unused;

  // 0x8000 negates to itself, which is the correct unsigned magnitude.
  assign mag = bus.in_score[D_WIDTH-1] ? (~bus.in_score + 16'd1) : bus.in_score;

  comp_cmp16 u_cmp (
    .a      (mag),
    .b      (best_mag),
    .result (cmp)
  );

  assign cmp_lt_unused = cmp[CMP_LT];

`ifdef ARGMAX_TIE_LAST_EN
  assign upd = cmp[CMP_GT] | cmp[CMP_EQ];
`else
  assign upd = cmp[CMP_GT] & ~cmp[CMP_EQ];
`endif

  assign accept = bus.in_valid & in_rdy;
  assign last   = (cnt == IDX_WIDTH'(CLASS_NUM - 1));

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      ST_SCAN: begin
        in_rdy = 1'b1;
        if (accept && last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_d = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SCAN;
    else     state_q <= state_d;
  end

  // First beat of a frame loads unconditionally, overwriting last frame's winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      best_mag  <= '0;
      best_idx  <= '0;
      best_sign <= 1'b0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (cnt == '0 || upd) begin
        best_mag  <= mag;
        best_idx  <= cnt;
        best_sign <= bus.in_score[D_WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_idx   = best_idx;
  assign bus.out_mag   = best_mag;
  assign bus.out_sign  = best_sign;
endmodule

// File: tb/tb_perc_argmax16.sv
module tb_perc_argmax16;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  perc_argmax16_if #(.IDX_WIDTH(4)) bus ();

  perc_argmax16 #(.CLASS_NUM(4), .IDX_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present one beat, wait (bounded) for in_ready, return #1 after acceptance.
  task automatic send_beat(input logic [15:0] s);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_score = s;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) chk("beat_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_score = 16'hDEAD;
  endtask

  task automatic send_frame(input logic [15:0] a, b, c, d, input int gap);
    logic [15:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      send_beat(v[i]);
      if (i == 2) chk("early_out_valid", {31'd0, bus.out_valid}, 32'd0);
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic chk_res(input string tag, input int idx, input int mag, input int sgn);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_idx"},   {28'd0, bus.out_idx},   32'(idx));
    chk({tag, "_mag"},   {16'd0, bus.out_mag},   32'(mag));
    chk({tag, "_sign"},  {31'd0, bus.out_sign},  32'(sgn));
    chk({tag, "_inrdy"}, {31'd0, bus.in_ready},  32'd0);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_cons_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_cons_inrdy"}, {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_score  = 16'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_idx",   {28'd0, bus.out_idx},   32'd0);
    chk("rst_out_mag",   {16'd0, bus.out_mag},   32'd0);
    chk("rst_out_sign",  {31'd0, bus.out_sign},  32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Largest magnitude is the negative beat
    send_frame(16'h0003, 16'hFFF0, 16'h0007, 16'h0002, 0);
    chk_res("f1", 1, 16'h0010, 1);
    consume("f1");

    // 0x8000 beats 0x7FFF
    send_frame(16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 0);
    chk_res("f2", 0, 16'h8000, 1);
    consume("f2");

    // Three-way tie at magnitude 5
    send_frame(16'h0005, 16'hFFFB, 16'h0005, 16'h0001, 0);
`ifdef ARGMAX_TIE_LAST_EN
    chk_res("tie", 2, 16'h0005, 0);
`else
    chk_res("tie", 0, 16'h0005, 0);
`endif
    consume("tie");

    // Backpressure with a next-frame beat waiting
    send_frame(16'h0001, 16'hFFFE, 16'h0000, 16'h0000, 0);
    chk_res("bp", 1, 16'h0002, 1);
    bus.in_valid = 1'b1;
    bus.in_score = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_idx",   {28'd0, bus.out_idx},   32'd1);
      chk("bp_hold_mag",   {16'd0, bus.out_mag},   32'h0002);
      chk("bp_hold_inrdy", {31'd0, bus.in_ready},  32'd0);
    end
    consume("bp");
    send_beat(16'h0100);
    send_beat(16'h0002);
    send_beat(16'h0003);
    send_beat(16'hFF00);
`ifdef ARGMAX_TIE_LAST_EN
    chk_res("bp_next", 3, 16'h0100, 1);
`else
    chk_res("bp_next", 0, 16'h0100, 0);
`endif
    consume("bp_next");

    // Bubbles between beats
    send_frame(16'h0004, 16'hFFF7, 16'h0006, 16'h0008, 2);
    chk_res("bub", 1, 16'h0009, 1);
    consume("bub");

    // Reset after two beats discards the partial frame
    send_beat(16'h7000);
    send_beat(16'h7000);
    #2 rst = 1'b1;
    #2;
    chk("midrst_mag",   {16'd0, bus.out_mag},   32'd0);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    send_frame(16'h0001, 16'h0002, 16'h0009, 16'h0004, 0);
    chk_res("postrst", 2, 16'h0009, 0);
    consume("postrst");

    // Back-to-back with out_ready held high
    bus.out_ready = 1'b1;
    send_frame(16'h000A, 16'hFFF5, 16'h0003, 16'h0002, 0);
    chk("b2b_a_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_a_idx",   {28'd0, bus.out_idx},   32'd1);
    chk("b2b_a_mag",   {16'd0, bus.out_mag},   32'd11);
    chk("b2b_a_sign",  {31'd0, bus.out_sign},  32'd1);
    t0 = cyc;
    send_frame(16'hFFFF, 16'h0000, 16'h0020, 16'hFFE0, 0);
    chk("b2b_b_valid", {31'd0, bus.out_valid}, 32'd1);
`ifdef ARGMAX_TIE_LAST_EN
    chk("b2b_b_idx",   {28'd0, bus.out_idx},   32'd3);
    chk("b2b_b_sign",  {31'd0, bus.out_sign},  32'd1);
`else
    chk("b2b_b_idx",   {28'd0, bus.out_idx},   32'd2);
    chk("b2b_b_sign",  {31'd0, bus.out_sign},  32'd0);
`endif
    chk("b2b_b_mag",    {16'd0, bus.out_mag},  32'h0020);
    chk("b2b_period",   32'(cyc - t0),         32'd5);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("b2b_end_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
